vga_raster_out: RTL and testbench

//  Raster timing generator and DAC output stage for the VGA display path.

---
 rtl/vga_raster_out_if.sv | 35 +++
 rtl/vga_raster_out.sv | 142 ++++++++++++++
 tb/tb_vga_raster_out.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_raster_out_if.sv
// Raster/pixel bus between the VGA output stage and the object drawers/mux.
// testPatternSel exists only when TEST_PATTERN_EN is defined.
interface vga_raster_out_if;
   logic [7:0]  RGBIn;
`ifdef TEST_PATTERN_EN
   logic        testPatternSel;
`endif
   logic [10:0] PixelX;
   logic [10:0] PixelY;
   logic        startOfFrame;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        hsyncN;
   logic        vsyncN;
   logic        blankN;

   modport master (
      input  RGBIn,
`ifdef TEST_PATTERN_EN
      input  testPatternSel,
`endif
      output PixelX, PixelY, startOfFrame,
      output vga_r, vga_g, vga_b, hsyncN, vsyncN, blankN
   );

   modport slave (
      output RGBIn,
`ifdef TEST_PATTERN_EN
      output testPatternSel,
`endif
      input  PixelX, PixelY, startOfFrame,
      input  vga_r, vga_g, vga_b, hsyncN, vsyncN, blankN
   );
endinterface

// File: rtl/vga_raster_out.sv
// Raster timing generator and RGB332 -> 4:4:4 DAC output stage for the VGA path.
// Build macro TEST_PATTERN_EN adds an 8-bar colour test pattern selected by testPatternSel.
module vga_raster_out #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic             clk,
   input  logic             resetN,
   vga_raster_out_if.master bus
);
   localparam int unsigned CW      = 11;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;

   typedef struct packed {
      logic act;
      logic hsn;
      logic vsn;
   } timing_t;

   localparam timing_t T_IDLE = '{act: 1'b0, hsn: 1'b1, vsn: 1'b1};

   logic [CW-1:0]          r_x;
   logic [CW-1:0]          r_y;
   logic [CW-1:0]          w_x_nxt;
   logic [CW-1:0]          w_y_nxt;
   logic                   r_sof;
   timing_t                w_raw;
   timing_t [PIPE_LAT:0]   r_stg;
   logic [7:0]             w_pix;
   logic [3:0]             r_vga_r;
   logic [3:0]             r_vga_g;
   logic [3:0]             r_vga_b;

   // Next raster position; PixelY advances only on the PixelX wrap
   always_comb begin
      w_x_nxt = r_x + CW'(1);
      w_y_nxt = r_y;
      if (r_x == CW'(H_TOTAL - 1)) begin
         w_x_nxt = '0;
         w_y_nxt = (r_y == CW'(V_TOTAL - 1)) ? '0 : r_y + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_x   <= '0;
         r_y   <= '0;
         r_sof <= 1'b0;
      end else begin
         r_x   <= w_x_nxt;
         r_y   <= w_y_nxt;
         r_sof <= (w_x_nxt == '0) && (w_y_nxt == '0);
      end
   end

   // Raw timing decoded from the current count (sync kept in active-low form)
   always_comb begin
      w_raw.act = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));
      w_raw.hsn = !((r_x >= CW'(HS_BEG)) && (r_x < CW'(HS_END)));
      w_raw.vsn = !((r_y >= CW'(VS_BEG)) && (r_y < CW'(VS_END)));
   end

   // Timing delay line: stage k holds the decode of the count k+1 clocks ago
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_stg <= {(PIPE_LAT + 1){T_IDLE}};
      else         r_stg <= {r_stg[PIPE_LAT-1:0], w_raw};
   end

`ifdef TEST_PATTERN_EN
   localparam int unsigned BW = 3 * PIPE_LAT;

   logic [BW-1:0] r_bar;

   function automatic logic [7:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 8'hFF;
         3'd1:    bar_colour = 8'hFC;
         3'd2:    bar_colour = 8'h1F;
         3'd3:    bar_colour = 8'h1C;
         3'd4:    bar_colour = 8'hE3;
         3'd5:    bar_colour = 8'hE0;
         3'd6:    bar_colour = 8'h03;
         default: bar_colour = 8'h00;
      endcase
   endfunction

   // Bar index delayed to line up with the object pipeline, like RGBIn
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_bar <= '0;
      else         r_bar <= BW'({r_bar, r_x[9:7]});
   end

   always_comb begin
      w_pix = bus.RGBIn;
      if (bus.testPatternSel) w_pix = bar_colour(r_bar[BW-1 -: 3]);
   end
`else
   always_comb begin
      w_pix = bus.RGBIn;
   end
`endif

   // Register the pixel with expansion; blanked while the matching act bit is low
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_vga_r <= '0;
         r_vga_g <= '0;
         r_vga_b <= '0;
      end else if (r_stg[PIPE_LAT-1].act) begin
         r_vga_r <= {w_pix[7:5], w_pix[7]};
         r_vga_g <= {w_pix[4:2], w_pix[4]};
         r_vga_b <= {w_pix[1:0], w_pix[1:0]};
      end else begin
         r_vga_r <= '0;
         r_vga_g <= '0;
         r_vga_b <= '0;
      end
   end

   assign bus.PixelX       = r_x;
   assign bus.PixelY       = r_y;
   assign bus.startOfFrame = r_sof;
   assign bus.vga_r        = r_vga_r;
   assign bus.vga_g        = r_vga_g;
   assign bus.vga_b        = r_vga_b;
   assign bus.hsyncN       = r_stg[PIPE_LAT].hsn;
   assign bus.vsyncN       = r_stg[PIPE_LAT].vsn;
   assign bus.blankN       = r_stg[PIPE_LAT].act;

endmodule

// File: tb/tb_vga_raster_out.sv
// Testbench for vga_raster_out: full horizontal timing, shortened vertical timing.
// Per-cycle reference model plus directed literal checks of line/frame timing, colour, alignment and reset.
module tb_vga_raster_out;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   // Short frame so several whole frames fit in a short run
   localparam int V_ACTIVE = 6;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam int PIPE_LAT = 1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int D        = PIPE_LAT + 1;

   logic clk    = 1'b0;
   logic resetN = 1'b1;

   vga_raster_out_if bus();

   vga_raster_out #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n        = 0;   // clock edges since the last reset release
   int cyc      = 0;
   int mode     = 2;
   bit tp_sel   = 1'b0;
   bit chk_en   = 1'b0;
   int n_checks = 0;
   int n_err    = 0;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) n <= 0;
      else         n <= n + 1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", nm, act, exp, n, $time);
      end
   endtask

   function automatic int px(input int k);
      return (k % FRAME) % H_TOTAL;
   endfunction

   function automatic int py(input int k);
      return (k % FRAME) / H_TOTAL;
   endfunction

   function automatic logic [7:0] bar_rgb(input int x);
      case ((x / 128) % 8)
         0:       return 8'hFF;
         1:       return 8'hFC;
         2:       return 8'h1F;
         3:       return 8'h1C;
         4:       return 8'hE3;
         5:       return 8'hE0;
         6:       return 8'h03;
         default: return 8'h00;
      endcase
   endfunction

   // Pixel the object mux produces for raster position number k
   function automatic logic [7:0] pix(input int k);
      int x;
      int y;
      x = px(k);
      y = py(k);
      if (tp_sel)      return bar_rgb(x);
      if (mode == 0)   return 8'hE0;
      if (mode == 1)   return (x == 0) ? 8'hFF : 8'h00;
      return 8'((x * 37 + y * 101) ^ (x / 4));
   endfunction

   function automatic int expand(input logic [7:0] p);
      int r;
      int g;
      int b;
      r = int'(p) / 32;
      g = (int'(p) / 4) % 8;
      b = int'(p) % 4;
      return (r * 2 + r / 4) * 256 + (g * 2 + g / 4) * 16 + (b * 4 + b);
   endfunction

   function automatic logic get_sig(input int sel);
      case (sel)
         0:       return bus.hsyncN;
         1:       return bus.vsyncN;
         2:       return bus.startOfFrame;
         default: return bus.blankN;
      endcase
   endfunction

   // Mux model drive plus per-cycle comparison against the reference model
   always @(negedge clk) begin
      int k;
      int x;
      int y;
      int e_act;
      int e_hsn;
      int e_vsn;
      int e_rgb;
      if (chk_en) begin
         if (!resetN) begin
            chk("rst_px", bus.PixelX, 0);
            chk("rst_py", bus.PixelY, 0);
            chk("rst_sof", bus.startOfFrame, 0);
            chk("rst_hsyncN", bus.hsyncN, 1);
            chk("rst_vsyncN", bus.vsyncN, 1);
            chk("rst_blankN", bus.blankN, 0);
            chk("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
         end else begin
            chk("px", bus.PixelX, px(n));
            chk("py", bus.PixelY, py(n));
            chk("sof", bus.startOfFrame, (n > 0 && px(n) == 0 && py(n) == 0) ? 1 : 0);
            k = n - D;
            e_act = 0; e_hsn = 1; e_vsn = 1; e_rgb = 0;
            if (k >= 0) begin
               x = px(k);
               y = py(k);
               e_act = (x < H_ACTIVE && y < V_ACTIVE) ? 1 : 0;
               e_hsn = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
               e_vsn = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
               if (e_act != 0) e_rgb = expand(pix(k));
            end
            chk("blankN", bus.blankN, e_act);
            chk("hsyncN", bus.hsyncN, e_hsn);
            chk("vsyncN", bus.vsyncN, e_vsn);
            chk("rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, e_rgb);
         end
      end
      bus.RGBIn = (resetN && n >= PIPE_LAT) ? pix(n - PIPE_LAT) : 8'h00;
   end

   task automatic do_reset();
      @(posedge clk);
      #2 resetN = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic do_release();
      @(posedge clk);
      #2 resetN = 1'b1;
   endtask

   task automatic wait_sig(input int sel, input logic v, input int budget, output int at);
      at = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (get_sig(sel) === v) begin
            at = cyc;
            return;
         end
      end
      n_checks++;
      n_err++;
      $display("FAIL wait_sig%0d: timeout after %0d cycles waiting for %0b", sel, budget, v);
   endtask

   initial begin
      int t1;
      int t2;
      int tr;
      int c;
      bit prev;
      bit pend;
      int lines;
`ifdef TEST_PATTERN_EN
      bus.testPatternSel = 1'b0;
`endif
      #1 resetN = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("init_hsyncN", bus.hsyncN, 1);
      chk("init_vsyncN", bus.vsyncN, 1);
      chk("init_blankN", bus.blankN, 0);

      // Line and frame timing with a pseudo-random pixel stream
      mode = 2;
      do_release();
      wait_sig(0, 1'b0, 2000, t1);
      wait_sig(0, 1'b1, 2000, tr);
      wait_sig(0, 1'b0, 2000, t2);
      chk("line_period", t2 - t1, 800);
      chk("hsync_width", tr - t1, 96);
      wait_sig(1, 1'b0, FRAME + 1000, t1);
      wait_sig(1, 1'b1, FRAME + 1000, tr);
      wait_sig(1, 1'b0, FRAME + 1000, t2);
      chk("frame_period", t2 - t1, 9600);
      chk("vsync_width", tr - t1, 1600);
      wait_sig(2, 1'b1, FRAME + 1000, t1);
      wait_sig(2, 1'b0, 10, tr);
      wait_sig(2, 1'b1, FRAME + 1000, t2);
      chk("sof_period", t2 - t1, 9600);
      chk("sof_width", tr - t1, 1);

      // Constant red input: F,0,0 while active, 0 while blanked
      do_reset();
      mode = 0;
      do_release();
      repeat (FRAME) begin
         @(negedge clk);
         chk("red_const", {bus.vga_r, bus.vga_g, bus.vga_b}, bus.blankN ? 32'hF00 : 32'h000);
      end

      // Alignment: white only at column 0 of each line
      do_reset();
      mode = 1;
      do_release();
      prev = 1'b0; pend = 1'b0; lines = 0;
      repeat (FRAME) begin
         @(negedge clk);
         if (pend) chk("align_next", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000);
         pend = 1'b0;
         if (bus.blankN && !prev) begin
            chk("align_first", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFFF);
            pend = 1'b1;
            lines++;
         end
         prev = bus.blankN;
      end
      chk("align_lines", lines, 6);

      // Mid-frame reset at (300,3)
      do_reset();
      mode = 2;
      do_release();
      c = 0;
      while (!(bus.PixelX == 11'd300 && bus.PixelY == 11'd3) && c < FRAME) begin
         @(posedge clk);
         #1 c++;
      end
      chk("reach_x", bus.PixelX, 300);
      chk("reach_y", bus.PixelY, 3);
      #1 resetN = 1'b0;
      #1;
      chk("mid_hsyncN", bus.hsyncN, 1);
      chk("mid_vsyncN", bus.vsyncN, 1);
      chk("mid_blankN", bus.blankN, 0);
      chk("mid_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
      chk("mid_px", bus.PixelX, 0);
      repeat (3) @(posedge clk);
      #2 resetN = 1'b1;
      #1;
      chk("rel_px", bus.PixelX, 0);
      chk("rel_py", bus.PixelY, 0);
      c = 0;
      while (bus.hsyncN !== 1'b0 && c < 2000) begin
         @(posedge clk);
         #1 c++;
      end
      chk("first_hs_fall", c, 658);

`ifdef TEST_PATTERN_EN
      // Colour bars on line 0
      do_reset();
      tp_sel = 1'b1;
      bus.testPatternSel = 1'b1;
      do_release();
      repeat (300) begin
         @(negedge clk);
         if (n - D == 0)   chk("bar0", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFFF);
         if (n - D == 127) chk("bar0_end", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFFF);
         if (n - D == 128) chk("bar1", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFF0);
         if (n - D == 256) chk("bar2", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h0FF);
      end
`endif

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
